mem_port_arbiter: RTL and testbench

- Shares the single instruction/data memory port between the fetch stage (I-port) and a data/probe requester (D-port).
- Decides one grant per cycle and drives the memory strobes. Returns read data to the owning requester after a fixed memory latency.
- Provides a lock mode so the D-port can take exclusive ownership after fetch reads in flight have drained.
- Sits between fetch/probe logic and memory in the pd-series top levels; it replaces the ad-hoc priority mux.

---
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter for the shared I/D memory port: starvation guard, lock/drain, latency-matched response routing.
// Optional build macro ARB_PERF_CNT_EN adds grant and conflict performance counters.
module mem_port_arbiter #(
    parameter int AWIDTH       = 32,
    parameter int DWIDTH       = 32,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_i,
    input  logic [AWIDTH-1:0] i_addr_i,
    output logic              i_gnt_o,
    output logic              i_rvalid_o,
    output logic [DWIDTH-1:0] i_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [AWIDTH-1:0] d_addr_i,
    input  logic [DWIDTH-1:0] d_wdata_i,
    input  logic              d_lock_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DWIDTH-1:0] d_rdata_o,
    output logic              lock_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]       perf_i_gnt_o,
    output logic [31:0]       perf_d_gnt_o,
    output logic [31:0]       perf_conflict_o,
`endif
    input  logic [DWIDTH-1:0] mem_data_i
);

    typedef enum logic [1:0] {ARB, DRAIN, LOCKED} state_e;

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_I    = 2'd1;
    localparam logic [1:0] TAG_D    = 2'd2;

    localparam int SW = $clog2(STARVE_LIMIT + 2);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    state_e                   state_q, state_d;
    logic [SW-1:0]            starve_q, starve_d;
    logic [MEM_LAT-1:0][1:0]  tag_q, tag_d;
    logic [1:0]               new_tag;
    logic                     i_busy;

    // Grants are forced low while reset is held so every output reads 0.
    always_comb begin
        i_gnt_o = 1'b0;
        d_gnt_o = 1'b0;
        if (rst) begin
            case (state_q)
                ARB: begin
                    if (i_req_i && d_req_i) begin
                        if (starve_q == LIMIT) i_gnt_o = 1'b1;
                        else                   d_gnt_o = 1'b1;
                    end else begin
                        i_gnt_o = i_req_i;
                        d_gnt_o = d_req_i;
                    end
                end
                default: d_gnt_o = d_req_i;
            endcase
        end
    end

    always_comb begin
        mem_addr_o     = '0;
        mem_data_o     = '0;
        mem_read_en_o  = 1'b0;
        mem_write_en_o = 1'b0;
        if (d_gnt_o) begin
            mem_addr_o     = d_addr_i;
            mem_data_o     = d_we_i ? d_wdata_i : '0;
            mem_read_en_o  = ~d_we_i;
            mem_write_en_o = d_we_i;
        end else if (i_gnt_o) begin
            mem_addr_o    = i_addr_i;
            mem_read_en_o = 1'b1;
        end
    end

    // An I grant made this cycle counts as in flight, so lock never overtakes it.
    always_comb begin
        i_busy = i_gnt_o;
        for (int k = 0; k < MEM_LAT; k++) begin
            if (tag_q[k] == TAG_I) i_busy = 1'b1;
        end
    end

    always_comb begin
        new_tag = TAG_NONE;
        if (d_gnt_o && !d_we_i) new_tag = TAG_D;
        else if (i_gnt_o)       new_tag = TAG_I;
        tag_d    = tag_q;
        tag_d[0] = new_tag;
        for (int k = 1; k < MEM_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (state_q == ARB) begin
            if (i_gnt_o || !i_req_i)
                starve_d = '0;
            else if (d_gnt_o && starve_q != LIMIT)
                starve_d = starve_q + SW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB: begin
                if (d_lock_i) state_d = i_busy ? DRAIN : LOCKED;
            end
            DRAIN: begin
                if (!d_lock_i)    state_d = ARB;
                else if (!i_busy) state_d = LOCKED;
            end
            LOCKED: begin
                if (!d_lock_i) state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ARB;
            starve_q <= '0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            tag_q    <= tag_d;
        end
    end

    assign lock_o     = (state_q == LOCKED);
    assign i_rvalid_o = rst && (tag_q[MEM_LAT-1] == TAG_I);
    assign d_rvalid_o = rst && (tag_q[MEM_LAT-1] == TAG_D);
    assign i_rdata_o  = i_rvalid_o ? mem_data_i : '0;
    assign d_rdata_o  = d_rvalid_o ? mem_data_i : '0;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_i_q, perf_i_d;
    logic [31:0] perf_d_q, perf_d_d;
    logic [31:0] perf_c_q, perf_c_d;
    logic        conflict;

    always_comb begin
        conflict = (i_req_i & ~i_gnt_o) | (d_req_i & ~d_gnt_o);
        perf_i_d = perf_i_q + 32'(i_gnt_o);
        perf_d_d = perf_d_q + 32'(d_gnt_o);
        perf_c_d = perf_c_q + 32'(conflict);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_i_q <= '0;
            perf_d_q <= '0;
            perf_c_q <= '0;
        end else begin
            perf_i_q <= perf_i_d;
            perf_d_q <= perf_d_d;
            perf_c_q <= perf_c_d;
        end
    end

    assign perf_i_gnt_o    = perf_i_q;
    assign perf_d_gnt_o    = perf_d_q;
    assign perf_conflict_o = perf_c_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table plus directed lock/reset sequences.
// A second instance with MEM_LAT=2 exercises the drain path.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        i_req = 0, d_req = 0, d_we = 0, d_lock = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
    logic [31:0] mem_rdata = 0;

    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, lock, m_re, m_we;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic        i_gnt_2, i_rvalid_2, d_gnt_2, d_rvalid_2, lock_2, m_re_2, m_we_2;
    logic [31:0] i_rdata_2, d_rdata_2, m_addr_2, m_wdata_2;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_i, perf_d, perf_c, perf_i_2, perf_d_2, perf_c_2;
`endif

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt),
        .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr),
        .d_wdata_i(d_wdata), .d_lock_i(d_lock), .d_gnt_o(d_gnt),
        .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata), .lock_o(lock),
        .mem_addr_o(m_addr), .mem_data_o(m_wdata),
        .mem_read_en_o(m_re), .mem_write_en_o(m_we),
`ifdef ARB_PERF_CNT_EN
        .perf_i_gnt_o(perf_i), .perf_d_gnt_o(perf_d),
        .perf_conflict_o(perf_c),
`endif
        .mem_data_i(mem_rdata)
    );

    mem_port_arbiter #(.MEM_LAT(2)) dut2 (
        .clk(clk), .rst(rst),
        .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt_2),
        .i_rvalid_o(i_rvalid_2), .i_rdata_o(i_rdata_2),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr),
        .d_wdata_i(d_wdata), .d_lock_i(d_lock), .d_gnt_o(d_gnt_2),
        .d_rvalid_o(d_rvalid_2), .d_rdata_o(d_rdata_2), .lock_o(lock_2),
        .mem_addr_o(m_addr_2), .mem_data_o(m_wdata_2),
        .mem_read_en_o(m_re_2), .mem_write_en_o(m_we_2),
`ifdef ARB_PERF_CNT_EN
        .perf_i_gnt_o(perf_i_2), .perf_d_gnt_o(perf_d_2),
        .perf_conflict_o(perf_c_2),
`endif
        .mem_data_i(mem_rdata)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Memory device: stores DUT writes, returns reads one cycle later.
    logic [31:0] wmem [logic [31:0]];
    logic [31:0] shadow [logic [31:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] dev_rd(input logic [31:0] a);
        if (wmem.exists(a)) return wmem[a];
        return dflt(a);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        if (shadow.exists(a)) return shadow[a];
        return dflt(a);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_we) wmem[m_addr] = m_wdata;
        mem_rdata <= m_re ? dev_rd(m_addr) : (32'hBAD0_0000 ^ 32'(cyc));
    end

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (!i_rvalid) chk("i_rdata_idle", i_rdata, 32'd0);
            if (!d_rvalid) chk("d_rdata_idle", d_rdata, 32'd0);
            if (i_rvalid || d_rvalid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk1("rv_both", i_rvalid & d_rvalid, 1'b0);
                    chk1("rv_port", d_rvalid, e.port);
                    chk("rv_data", d_rvalid ? d_rdata : i_rdata, e.data);
                    chk("rv_cycle", 32'(cyc), 32'(e.due));
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                chk("missing_rvalid", 32'(cyc), 32'(e.due + 1000));
            end
        end
    end

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        dl;
        logic        eig;
        logic        edg;
    } vec_t;

    function automatic vec_t mk(input logic ir, input logic [31:0] ia,
                                input logic dr, input logic dwe,
                                input logic [31:0] da, input logic [31:0] dwd,
                                input logic dl, input logic eig, input logic edg);
        vec_t v;
        v = '{ir, ia, dr, dwe, da, dwd, dl, eig, edg};
        return v;
    endfunction

    task automatic step(input vec_t v, input string tag);
        logic [31:0] ea, ed;
        logic        ere, ewe;
        @(posedge clk); #1;
        i_req = v.ir; i_addr = v.ia;
        d_req = v.dr; d_we = v.dwe; d_addr = v.da; d_wdata = v.dwd;
        d_lock = v.dl;
        @(negedge clk);
        ea = 0; ed = 0; ere = 0; ewe = 0;
        if (v.edg) begin
            ea = v.da; ed = v.dwe ? v.dwd : 32'd0; ere = ~v.dwe; ewe = v.dwe;
        end else if (v.eig) begin
            ea = v.ia; ere = 1'b1;
        end
        chk1({tag, ".i_gnt"}, i_gnt, v.eig);
        chk1({tag, ".d_gnt"}, d_gnt, v.edg);
        chk1({tag, ".i_gnt2"}, i_gnt_2, v.eig);
        chk1({tag, ".d_gnt2"}, d_gnt_2, v.edg);
        chk({tag, ".m_addr"}, m_addr, ea);
        chk({tag, ".m_wdata"}, m_wdata, ed);
        chk1({tag, ".m_re"}, m_re, ere);
        chk1({tag, ".m_we"}, m_we, ewe);
        chk1({tag, ".lock"}, lock, 1'b0);
        if (v.eig) sb.push_back('{1'b0, exp_rd(v.ia), cyc + 1});
        if (v.edg && !v.dwe) sb.push_back('{1'b1, exp_rd(v.da), cyc + 1});
        if (v.edg && v.dwe) shadow[v.da] = v.dwd;
    endtask

    vec_t tbl [13];
    vec_t idle;

    initial begin
        int seen;
        logic got;
`ifdef ARB_PERF_CNT_EN
        logic [31:0] pi0, pd0, pc0;
`endif
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            tbl[i] = mk(1, 32'h1000, 1, 0, 32'h2000 + 32'(4 * i), 0, 0,
                        (i % 5) == 4, (i % 5) != 4);
        tbl[10] = mk(0, 0, 1, 1, 32'h100, 32'hDEAD_BEEF, 0, 0, 1);
        tbl[11] = mk(0, 0, 1, 0, 32'h100, 0, 0, 0, 1);
        tbl[12] = idle;

        // Reset held with both ports requesting.
        repeat (2) @(posedge clk);
        #1 i_req = 1; d_req = 1; i_addr = 32'h40; d_addr = 32'h80;
        @(negedge clk);
        chk1("rst.i_gnt", i_gnt, 0);
        chk1("rst.d_gnt", d_gnt, 0);
        chk1("rst.i_rvalid", i_rvalid, 0);
        chk1("rst.d_rvalid", d_rvalid, 0);
        chk("rst.i_rdata", i_rdata, 0);
        chk("rst.d_rdata", d_rdata, 0);
        chk1("rst.lock", lock, 0);
        chk("rst.m_addr", m_addr, 0);
        chk("rst.m_wdata", m_wdata, 0);
        chk1("rst.m_re", m_re, 0);
        chk1("rst.m_we", m_we, 0);
`ifdef ARB_PERF_CNT_EN
        chk("rst.perf_i", perf_i, 0);
        chk("rst.perf_c", perf_c, 0);
`endif
        @(posedge clk); #1;
        rst = 1; i_req = 0; d_req = 0;
        step(mk(1, 32'h0, 0, 0, 0, 0, 0, 1, 0), "first_fetch");
        step(idle, "idle0");
`ifdef ARB_PERF_CNT_EN
        pi0 = perf_i; pd0 = perf_d; pc0 = perf_c;
`endif

        // Starvation run then D write/read.
        for (int i = 0; i < 13; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
`ifdef ARB_PERF_CNT_EN
            if (i == 10) begin
                chk("perf.d_gnt", perf_d - pd0, 8);
                chk("perf.i_gnt", perf_i - pi0, 2);
                chk("perf.conflict", perf_c - pc0, 10);
            end
`endif
        end

        // Lock while two fetch reads are in flight.
        step(mk(1, 32'h200, 0, 0, 0, 0, 0, 1, 0), "lockA");
        step(mk(1, 32'h204, 0, 0, 0, 0, 0, 1, 0), "lockB");
        @(posedge clk); #1 i_req = 0; d_lock = 1;
        @(negedge clk);
        chk1("lockC.lock2", lock_2, 0);
        chk1("lockC.i_gnt", i_gnt, 0);
        seen = i_rvalid_2 ? 1 : 0;
        got = 0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(posedge clk); #1 i_req = 1; i_addr = 32'h208;
            @(negedge clk);
            chk1("drain.i_gnt", i_gnt, 0);
            chk1("drain.i_gnt2", i_gnt_2, 0);
            if (lock_2) begin
                got = 1;
                chk("drain.rvalids_before_lock", 32'(seen), 2);
                chk1("drain.lock_dut", lock, 1);
            end else if (i_rvalid_2) begin
                seen++;
            end
        end
        chk1("lock_reached", got, 1);
        @(posedge clk); #1 d_lock = 0;
        @(negedge clk);
        chk1("unlock.still_locked", lock_2, 1);
        chk1("unlock.i_gnt", i_gnt, 0);
        step(mk(1, 32'h208, 0, 0, 0, 0, 0, 1, 0), "unlock_fetch");
        step(idle, "idle1");

        // Reset with a D read in flight.
        for (int k = 0; k < 3; k++)
            step(mk(1, 32'h300, 1, 0, 32'h400 + 32'(4 * k), 0, 0, 0, 1),
                 $sformatf("pre_rst%0d", k));
        @(posedge clk); #1;
        rst = 0; sb.delete(); i_req = 0; d_req = 0;
        #2 rst = 1;
        @(negedge clk);
        chk1("mid_rst.d_rvalid", d_rvalid, 0);
        chk1("mid_rst.d_rvalid2", d_rvalid_2, 0);
        @(negedge clk);
        chk1("mid_rst.d_rvalid_b", d_rvalid, 0);
        chk1("mid_rst.d_rvalid2_b", d_rvalid_2, 0);
        for (int k = 0; k < 5; k++)
            step(mk(1, 32'h500, 1, 0, 32'h600 + 32'(4 * k), 0, 0, k == 4, k != 4),
                 $sformatf("post_rst%0d", k));
        step(idle, "idle2");
        step(idle, "idle3");
        chk("sb_empty", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

endmodule
